// File: rtl/gpioemu_pkg.sv
// Shared register map, status bits and state encodings for the
// gpioemu bus initiator and its slave model.
package gpioemu_pkg;

   localparam logic [15:0] REG_A1  = 16'h0380;
   localparam logic [15:0] REG_A2  = 16'h0388;
   localparam logic [15:0] REG_W   = 16'h0390;
   localparam logic [15:0] REG_L   = 16'h0398;
   localparam logic [15:0] REG_CTL = 16'h03A0;

   localparam int STAT_DONE  = 1;
   localparam int STAT_VALID = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_A1,
      S_WR_A2,
      S_WR_CTL,
      S_RD_STAT,
      S_GAP,
      S_RD_W,
      S_RD_L,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_SETUP,
      P_STROBE,
      P_HOLD
   } phase_t;

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// One slave strobe access: SETUP, STROBE_LEN strobe cycles, HOLD.
// A new start is accepted in HOLD so accesses can run back to back.
module gpioemu_bus_cycle
   import gpioemu_pkg::*;
#(
   parameter int STROBE_LEN = 2
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic        rnw,
   input  logic [15:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_out,
   input  logic [31:0] sdata_in
);

   localparam logic [7:0] CNT_LAST = 8'(STROBE_LEN - 1);

   phase_t     phase;
   logic       rnw_q;
   logic [7:0] cnt;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         phase     <= P_IDLE;
         rnw_q     <= 1'b0;
         cnt       <= '0;
         saddress  <= '0;
         sdata_out <= '0;
         srd       <= 1'b0;
         swr       <= 1'b0;
      end else begin
         unique case (phase)
            P_IDLE, P_HOLD: begin
               if (start) begin
                  phase    <= P_SETUP;
                  rnw_q    <= rnw;
                  saddress <= addr;
                  if (!rnw) sdata_out <= wdata;
               end else begin
                  phase <= P_IDLE;
               end
            end
            P_SETUP: begin
               phase <= P_STROBE;
               cnt   <= '0;
               srd   <= rnw_q;
               swr   <= !rnw_q;
            end
            P_STROBE: begin
               if (cnt == CNT_LAST) begin
                  phase <= P_HOLD;
                  srd   <= 1'b0;
                  swr   <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: phase <= P_IDLE;
         endcase
      end
   end

   // Read data is consumed by the sequencer in the HOLD cycle itself.
   assign busy  = (phase != P_IDLE);
   assign done  = (phase == P_HOLD);
   assign rdata = sdata_in;

endmodule

// File: rtl/gpioemu_host.sv
// Sequences one multiply command over the gpioemu strobe bus:
// write A1, A2, start, poll status, read W and L, return result.
module gpioemu_host
   import gpioemu_pkg::*;
#(
   parameter int          STROBE_LEN = 2,
   parameter int          POLL_GAP   = 4,
   parameter int          POLL_MAX   = 64,
   parameter logic [15:0] ADDR_A1    = REG_A1,
   parameter logic [15:0] ADDR_A2    = REG_A2,
   parameter logic [15:0] ADDR_W     = REG_W,
   parameter logic [15:0] ADDR_L     = REG_L,
   parameter logic [15:0] ADDR_CTL   = REG_CTL
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_a1,
   input  logic [23:0] cmd_a2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_w,
   output logic [23:0] res_l,
   output logic        res_ok,
   output logic        res_timeout,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_out,
   input  logic [31:0] sdata_in
);

   localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);
   localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

   state_t      state, nxt;
   logic        out_en;
   logic [23:0] a2_q;
   logic [15:0] poll_cnt, gap_cnt;
   logic        start, rnw, busy, done;
   logic [15:0] addr;
   logic [31:0] wdata, rdata;

   gpioemu_bus_cycle #(.STROBE_LEN(STROBE_LEN)) u_bus (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (start),
      .rnw       (rnw),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .saddress  (saddress),
      .srd       (srd),
      .swr       (swr),
      .sdata_out (sdata_out),
      .sdata_in  (sdata_in)
   );

   // Each access is launched on the edge that enters its state.
   always_comb begin
      nxt   = state;
      start = 1'b0;
      rnw   = 1'b0;
      addr  = ADDR_A1;
      wdata = '0;
      unique case (state)
         S_IDLE: if (cmd_valid) begin
            nxt   = S_WR_A1;
            start = 1'b1;
            addr  = ADDR_A1;
            wdata = {8'h0, cmd_a1};
         end
         S_WR_A1: if (done) begin
            nxt   = S_WR_A2;
            start = 1'b1;
            addr  = ADDR_A2;
            wdata = {8'h0, a2_q};
         end
         S_WR_A2: if (done) begin
            nxt   = S_WR_CTL;
            start = 1'b1;
            addr  = ADDR_CTL;
         end
         S_WR_CTL: if (done) begin
            nxt   = S_RD_STAT;
            start = 1'b1;
            rnw   = 1'b1;
            addr  = ADDR_CTL;
         end
         S_RD_STAT: if (done) begin
            if (rdata[STAT_DONE]) begin
               nxt   = S_RD_W;
               start = 1'b1;
               rnw   = 1'b1;
               addr  = ADDR_W;
            end else if (poll_cnt == POLL_LAST) begin
               nxt = S_RESP;
            end else if (POLL_GAP == 0) begin
               nxt   = S_RD_STAT;
               start = 1'b1;
               rnw   = 1'b1;
               addr  = ADDR_CTL;
            end else begin
               nxt = S_GAP;
            end
         end
         S_GAP: if (gap_cnt == GAP_LAST && !busy) begin
            nxt   = S_RD_STAT;
            start = 1'b1;
            rnw   = 1'b1;
            addr  = ADDR_CTL;
         end
         S_RD_W: if (done) begin
            nxt   = S_RD_L;
            start = 1'b1;
            rnw   = 1'b1;
            addr  = ADDR_L;
         end
         S_RD_L: if (done) nxt = S_RESP;
         S_RESP: if (res_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= S_IDLE;
         out_en      <= 1'b0;
         a2_q        <= '0;
         poll_cnt    <= '0;
         gap_cnt     <= '0;
         res_w       <= '0;
         res_l       <= '0;
         res_ok      <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         state   <= nxt;
         out_en  <= 1'b1;
         gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;
         if (state == S_IDLE && cmd_valid) begin
            a2_q     <= cmd_a2;
            poll_cnt <= '0;
         end
         if (state == S_RD_STAT && done) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (rdata[STAT_DONE]) begin
               res_ok <= rdata[STAT_VALID];
            end else if (poll_cnt == POLL_LAST) begin
               res_timeout <= 1'b1;
               res_w       <= '0;
               res_l       <= '0;
               res_ok      <= 1'b0;
            end
         end
         if (state == S_RD_W && done) res_w <= rdata;
         if (state == S_RD_L && done) res_l <= rdata[23:0];
         if (state == S_RESP && res_ready) res_timeout <= 1'b0;
      end
   end

   // out_en keeps cmd_ready low while n_reset is asserted.
   assign cmd_ready = out_en && (state == S_IDLE);
   assign res_valid = (state == S_RESP);

endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host with a behavioural gpioemu slave
// and a bus monitor checking strobe shape and poll spacing.
module tb_gpioemu_host;
   import gpioemu_pkg::*;

   localparam int SL = 3;
   localparam int PG = 4;
   localparam int PM = 4;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [23:0] cmd_a1 = '0;
   logic [23:0] cmd_a2 = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_w;
   logic [23:0] res_l;
   logic        res_ok;
   logic        res_timeout;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;

   always #5 clk = ~clk;

   gpioemu_host #(.STROBE_LEN(SL), .POLL_GAP(PG), .POLL_MAX(PM)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a1      (cmd_a1),
      .cmd_a2      (cmd_a2),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_w       (res_w),
      .res_l       (res_l),
      .res_ok      (res_ok),
      .res_timeout (res_timeout),
      .saddress    (saddress),
      .srd         (srd),
      .swr         (swr),
      .sdata_out   (sdata_out),
      .sdata_in    (sdata_in)
   );

   typedef struct packed {
      logic        rnw;
      logic [15:0] addr;
      logic [31:0] data;
   } acc_t;

   logic [23:0] s_a1 = '0;
   logic [23:0] s_a2 = '0;
   logic [47:0] prod;
   int          stat_cnt = 0;
   int          done_at = 0;

   assign prod = s_a1 * s_a2;

   always_comb begin
      sdata_in = 32'hDEAD_BEEF;
      if (saddress == REG_CTL)
         sdata_in = {30'h0, (done_at != 0 && stat_cnt >= done_at),
                     (prod[47:32] == 16'h0)};
      else if (saddress == REG_W)
         sdata_in = prod[31:0];
      else if (saddress == REG_L)
         sdata_in = {8'hA5, 24'($countones(prod[31:0]))};
   end

   logic        p_rd = 1'b0, p_wr = 1'b0, last_stat = 1'b0;
   logic [15:0] p_addr = '0, pulse_addr = '0;
   int run = 0, cyc = 0, pulses = 0, last_fall = 0;
   int both_v = 0, len_v = 0, addr_v = 0, gap_v = 0;
   acc_t trace[$];

   always @(negedge clk) begin
      cyc++;
      if (!n_reset) begin
         run = 0;
         last_stat = 1'b0;
      end else begin
         if (srd && swr) both_v++;
         if ((srd || swr) && !(p_rd || p_wr)) begin
            if (saddress !== p_addr) addr_v++;
            pulse_addr = saddress;
            run = 1;
            pulses++;
            trace.push_back({srd, saddress, sdata_out});
            if (swr) begin
               if (saddress == REG_A1) s_a1 = sdata_out[23:0];
               if (saddress == REG_A2) s_a2 = sdata_out[23:0];
               if (saddress == REG_CTL) stat_cnt = 0;
            end
            if (srd && saddress == REG_CTL) begin
               stat_cnt++;
               if (last_stat && (cyc - last_fall) != PG + 2) gap_v++;
            end
            last_stat = 1'b0;
         end else if (srd || swr) begin
            run++;
            if (saddress !== pulse_addr) addr_v++;
         end else if (p_rd || p_wr) begin
            if (run != SL) len_v++;
            if (saddress !== pulse_addr) addr_v++;
            if (p_rd && saddress == REG_CTL) begin
               last_fall = cyc;
               last_stat = 1'b1;
            end
         end
      end
      p_rd = srd;
      p_wr = swr;
      p_addr = saddress;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [23:0] a1, input logic [23:0] a2);
      int n = 0;
      @(negedge clk);
      cmd_a1 = a1;
      cmd_a2 = a2;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", {31'h0, cmd_ready}, 32'h1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!res_valid && lat < 400);
      chk("res_valid_wait", {31'h0, res_valid}, 32'h1);
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("ack_valid_low", {31'h0, res_valid}, 32'h0);
      chk("ack_ready_high", {31'h0, cmd_ready}, 32'h1);
      chk("ack_to_clear", {31'h0, res_timeout}, 32'h0);
   endtask

   typedef struct {
      logic [23:0] a1;
      logic [23:0] a2;
      int          done_at;
      logic [31:0] w;
      logic [23:0] l;
      logic        ok;
      logic        to;
      int          lat;
   } vec_t;

   vec_t vt[8];
   acc_t exp_tr[7];

   initial begin
      int lat, base, n_stat, n_w, n_l, bad, n;

      vt[0] = '{24'h3, 24'h5, 2, 32'h0000000F, 24'd4, 1'b1, 1'b0, 40};
      vt[1] = '{24'hFFFFFF, 24'hFFFFFF, 1, 32'hFE000001, 24'd8, 1'b0, 1'b0, 31};
      vt[2] = '{24'h0, 24'h1234, 1, 32'h0, 24'd0, 1'b1, 1'b0, 31};
      vt[3] = '{24'h1000, 24'h1000, 3, 32'h01000000, 24'd1, 1'b1, 1'b0, 49};
      vt[4] = '{24'h10000, 24'h10000, 1, 32'h0, 24'd0, 1'b0, 1'b0, 31};
      vt[5] = '{24'h7, 24'h9, 0, 32'h0, 24'd0, 1'b0, 1'b1, 48};
      vt[6] = '{24'hABCDEF, 24'h2, 4, 32'h01579BDE, 24'd17, 1'b1, 1'b0, 58};
      vt[7] = '{24'hFFFFFF, 24'h1, 2, 32'h00FFFFFF, 24'd24, 1'b1, 1'b0, 40};

      exp_tr[0] = {1'b0, REG_A1, 32'h3};
      exp_tr[1] = {1'b0, REG_A2, 32'h5};
      exp_tr[2] = {1'b0, REG_CTL, 32'h0};
      exp_tr[3] = {1'b1, REG_CTL, 32'h0};
      exp_tr[4] = {1'b1, REG_CTL, 32'h0};
      exp_tr[5] = {1'b1, REG_W, 32'h0};
      exp_tr[6] = {1'b1, REG_L, 32'h0};

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
      chk("rst_saddress", {16'h0, saddress}, 32'h0);
      chk("rst_strobes", {30'h0, srd, swr}, 32'h0);
      chk("rst_res_w", res_w, 32'h0);
      n_reset = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);

      for (int i = 0; i < 8; i++) begin
         done_at = vt[i].done_at;
         base = trace.size();
         issue(vt[i].a1, vt[i].a2);
         wait_res(lat);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_w", i), res_w, vt[i].w);
         chk($sformatf("v%0d_l", i), {8'h0, res_l}, {8'h0, vt[i].l});
         chk($sformatf("v%0d_ok", i), {31'h0, res_ok}, {31'h0, vt[i].ok});
         chk($sformatf("v%0d_to", i), {31'h0, res_timeout},
             {31'h0, vt[i].to});
         chk($sformatf("v%0d_rdy", i), {31'h0, cmd_ready}, 32'h0);
         n_stat = 0;
         n_w = 0;
         n_l = 0;
         for (int k = base; k < trace.size(); k++) begin
            if (trace[k].rnw && trace[k].addr == REG_CTL) n_stat++;
            if (trace[k].rnw && trace[k].addr == REG_W) n_w++;
            if (trace[k].rnw && trace[k].addr == REG_L) n_l++;
         end
         chk($sformatf("v%0d_polls", i), n_stat,
             (vt[i].done_at == 0) ? PM : vt[i].done_at);
         chk($sformatf("v%0d_wl_reads", i), n_w + n_l, vt[i].to ? 0 : 2);
         if (i == 0) begin
            chk("trace_len", trace.size() - base, 7);
            for (int k = 0; k < 7; k++) begin
               if (trace.size() > base + k) begin
                  chk($sformatf("trace%0d_addr", k),
                      {15'h0, trace[base+k].rnw, trace[base+k].addr},
                      {15'h0, exp_tr[k].rnw, exp_tr[k].addr});
                  if (!exp_tr[k].rnw)
                     chk($sformatf("trace%0d_data", k),
                         trace[base+k].data, exp_tr[k].data);
               end
            end
         end
         ack();
      end

      done_at = 1;
      issue(24'd6, 24'd7);
      wait_res(lat);
      cmd_a1 = 24'd100;
      cmd_a2 = 24'd3;
      cmd_valid = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!res_valid || cmd_ready || res_w !== 32'd42 || res_l !== 24'd3)
            bad++;
      end
      chk("bp_stable", bad, 0);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_res(lat);
      chk("b2b_lat", lat, 31);
      chk("b2b_w", res_w, 32'h12C);
      chk("b2b_l", {8'h0, res_l}, 32'd4);
      ack();

      done_at = 1;
      issue(24'd9, 24'd11);
      n = 0;
      while (!(swr && saddress == REG_A2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_a2_strobe", {31'h0, swr}, 32'h1);
      #2 n_reset = 1'b0;
      #1;
      chk("mid_swr", {31'h0, swr}, 32'h0);
      chk("mid_srd", {31'h0, srd}, 32'h0);
      chk("mid_saddress", {16'h0, saddress}, 32'h0);
      chk("mid_sdata_out", sdata_out, 32'h0);
      chk("mid_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("mid_res_valid", {31'h0, res_valid}, 32'h0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
      issue(24'h123, 24'h456);
      wait_res(lat);
      chk("post_rst_lat", lat, 31);
      chk("post_rst_w", res_w, 32'h0004EDC2);
      chk("post_rst_l", {8'h0, res_l}, 32'd10);
      chk("post_rst_ok", {31'h0, res_ok}, 32'h1);
      ack();

      chk("strobe_overlap", both_v, 0);
      chk("strobe_len", len_v, 0);
      chk("addr_stable", addr_v, 0);
      chk("poll_gap", gap_v, 0);
      chk("pulses_seen", {31'h0, pulses > 50}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
